datapath_mem_seq: RTL and testbench
===================================

// Module: datapath_mem_seq
// PURPOSE
//  Multicycle memory sequencer between datapath control and datapath_cache_if.
//  Owns PC register, fetch/data-access FSM and LL/SC link register.
//  Serialises ifetch and data ops: at most one cache request is outstanding.
//  Adds atomic (LL/SC) support with snoop-driven link invalidation.
// PARAMETERS
//  ADDR_W   32  address width; link compare uses [ADDR_W-1:2] (word granularity)
//  DATA_W   32  instruction/data word width
//  PC_INIT  0   PC value loaded on reset
// PORTS
//  CLK          in   1       clock; all state updates on rising edge
//  RST          in   1       synchronous reset, active-high
//  ihit         in   1       instruction cache hit; imemload valid this cycle
//  imemload     in   DATA_W  fetched instruction
//  dhit         in   1       data cache hit; dmemload valid this cycle
//  dmemload     in   DATA_W  load data
//  imemREN      out  1       instruction read request
//  imemaddr     out  ADDR_W  fetch address (= pc)
//  dmemREN      out  1       data read request
//  dmemWEN      out  1       data write request
//  datomic      out  1       current data op is LL or SC
//  dmemstore    out  DATA_W  store data
//  dmemaddr     out  ADDR_W  data address
//  halt         out  1       sticky halt to cache/system
//  instr        out  DATA_W  latched instruction, stable from EXEC entry
//  instr_vld    out  1       1-cycle pulse on EXEC entry after fetch
//  pc           out  ADDR_W  current PC
//  pc_we        in   1       EXEC only: commit pc_next, start next fetch
//  pc_next      in   ADDR_W  next PC
//  mem_req      in   1       EXEC only: start data op
//  mem_wr       in   1       1 = store/SC, 0 = load/LL
//  mem_atomic   in   1       1 = LL (rd) / SC (wr)
//  mem_addr     in   ADDR_W  data op address
//  mem_wdata    in   DATA_W  store data
//  mem_done     out  1       1-cycle pulse: data op complete, mem_rdata valid
//  mem_rdata    out  DATA_W  load data; SC result 1 = success, 0 = fail
//  halt_req     in   1       EXEC only: enter HALT
//  snoop_inv    in   1       remote invalidate; pulse
//  snoop_addr   in   ADDR_W  address of remote invalidate
// BEHAVIOUR
//  Reset (RST=1 at edge): state=FETCH, pc=PC_INIT, link_vld=0, instr=0,
//   mem_rdata=0, halt=0. Outputs are combinational from state, so imemREN=1,
//   imemaddr=PC_INIT in the first cycle after RST deasserts.
//   All other outputs are 0 after reset.
//  FSM states: FETCH, EXEC, DMEM, SCFAIL, HALT.
//  FETCH: imemREN=1, imemaddr=pc. dhit is ignored. On ihit: instr<=imemload,
//   go to EXEC. instr_vld is high for the first EXEC cycle only.
//  EXEC: no cache request. Priority when several inputs are high:
//   halt_req > mem_req > pc_we.
//   - halt_req: go to HALT.
//   - mem_req: latch mem_* inputs. SC with link miss goes to SCFAIL;
//     every other op goes to DMEM.
//   - pc_we: pc<=pc_next, go to FETCH.
//   - none: stay in EXEC.
//  DMEM: drive dmemREN=!wr, dmemWEN=wr, datomic=atomic, dmemaddr/dmemstore
//   from latched values, held stable until dhit. On dhit: mem_done=1 in the
//   same cycle, go to EXEC.
//   - Load data: mem_rdata=dmemload; it is registered and holds until the next op.
//   - SC: mem_rdata=1.
//  SCFAIL: no cache request. mem_done=1 and mem_rdata=0 for one cycle, then EXEC.
//  HALT: halt=1, no requests. Stays in HALT until RST.
//  Link register:
//   - LL completing (dhit): link_addr<=addr, link_vld<=1.
//   - Link hit: link_vld && addr[ADDR_W-1:2]==link_addr[ADDR_W-1:2].
//   - SC completing: link_vld<=0.
//   - Plain store completing to a link-hit address: link_vld<=0.
//   - snoop_inv to a link-hit address: link_vld<=0 in any state.
//  Simultaneous events:
//   - snoop_inv matching the link in the same cycle as SC mem_req in EXEC:
//     the snoop wins and the SC goes to SCFAIL.
//   - snoop_inv matching the link while an SC is in DMEM: the SC is already
//     committed to the cache and still reports 1.
//   - LL dhit and matching snoop in the same cycle: the LL set wins (link_vld=1).
//  RST mid-operation, in any state: back to reset values next cycle and the
//   pending request is dropped.
//  Reads of pc_we/mem_req/halt_req outside EXEC are ignored.
// TESTING
//  1 RST, then ihit=1 after 2 cycles with imemload=0x8C220004.
//    -> imemaddr=0 while in FETCH; instr=0x8C220004; instr_vld pulses once.
//  2 Load mem_addr=0x100 with dhit held off 3 cycles, dmemload=0xDEADBEEF.
//    -> dmemREN=1 and dmemaddr=0x100 stable 4 cycles; mem_done=1 with
//       mem_rdata=0xDEADBEEF on the dhit cycle.
//  3 LL 0x200, then SC 0x200 wdata=5.
//    -> SC issues dmemWEN=1, datomic=1; mem_rdata=1. A repeated SC 0x200
//       then fails: no WEN, mem_rdata=0.
//  4 LL 0x200, then snoop_inv snoop_addr=0x202, then SC 0x200.
//    -> SCFAIL; dmemWEN stays 0; mem_rdata=0.
//  5 pc_we=1, pc_next=0x40 together with halt_req=1.
//    -> HALT, halt=1, pc unchanged, no further imemREN; RST clears halt.
//  6 RST asserted while in DMEM with dmemWEN=1.
//    -> next cycle dmemWEN=0, imemREN=1, pc=PC_INIT, link_vld=0.

Source files
------------

// File: rtl/datapath_mem_seq.sv
// Multicycle memory sequencer: owns the PC, serialises instruction fetch and data
// access so that only one cache request is outstanding, and tracks the LL/SC link.
module datapath_mem_seq #(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              RST,
  // instruction side of the cache
  input  logic              ihit,
  input  logic [DATA_W-1:0] imemload,
  output logic              imemREN,
  output logic [ADDR_W-1:0] imemaddr,
  // data side of the cache
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              datomic,
  output logic [DATA_W-1:0] dmemstore,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic              halt,
  // datapath control side
  output logic [DATA_W-1:0] instr,
  output logic              instr_vld,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_we,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic              mem_atomic,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              halt_req,
  // coherence snoop
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr
);

  localparam int WORD_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_DMEM   = 3'd2,
    S_SCFAIL = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_vld_q, instr_vld_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [WORD_W-1:0]   link_word_q, link_word_d;
  logic                link_vld_q, link_vld_d;
  logic                op_wr_q, op_wr_d;
  logic                op_atomic_q, op_atomic_d;
  logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
  logic [DATA_W-1:0]   op_wdata_q, op_wdata_d;

  logic snoop_hit;
  logic link_live;
  logic req_link_hit;
  logic op_link_hit;
  logic unused_bits;

  // byte offset bits never take part in the word-granular link compare
  assign unused_bits = ^snoop_addr[1:0];

  assign snoop_hit    = snoop_inv && link_vld_q &&
                        (snoop_addr[ADDR_W-1:2] == link_word_q);
  // a matching snoop in the same cycle already kills the link for an SC decision
  assign link_live    = link_vld_q && !snoop_hit;
  assign req_link_hit = link_live && (mem_addr[ADDR_W-1:2] == link_word_q);
  assign op_link_hit  = link_vld_q && (op_addr_q[ADDR_W-1:2] == link_word_q);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_vld_d = 1'b0;
    rdata_d     = rdata_q;
    link_word_d = link_word_q;
    link_vld_d  = link_vld_q;
    op_wr_d     = op_wr_q;
    op_atomic_d = op_atomic_q;
    op_addr_d   = op_addr_q;
    op_wdata_d  = op_wdata_q;

    if (snoop_hit) begin
      link_vld_d = 1'b0;
    end

    unique case (state_q)
      S_FETCH: begin
        if (ihit) begin
          instr_d     = imemload;
          instr_vld_d = 1'b1;
          state_d     = S_EXEC;
        end
      end

      S_EXEC: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (mem_req) begin
          op_wr_d     = mem_wr;
          op_atomic_d = mem_atomic;
          op_addr_d   = mem_addr;
          op_wdata_d  = mem_wdata;
          if (mem_wr && mem_atomic && !req_link_hit) begin
            state_d = S_SCFAIL;
          end else begin
            state_d = S_DMEM;
          end
        end else if (pc_we) begin
          pc_d    = pc_next;
          state_d = S_FETCH;
        end
      end

      S_DMEM: begin
        if (dhit) begin
          state_d = S_EXEC;
          if (!op_wr_q) begin
            rdata_d = dmemload;
            // LL set overrides a same-cycle snoop clear
            if (op_atomic_q) begin
              link_word_d = op_addr_q[ADDR_W-1:2];
              link_vld_d  = 1'b1;
            end
          end else if (op_atomic_q) begin
            rdata_d    = {{(DATA_W-1){1'b0}}, 1'b1};
            link_vld_d = 1'b0;
          end else if (op_link_hit) begin
            link_vld_d = 1'b0;
          end
        end
      end

      S_SCFAIL: begin
        rdata_d    = '0;
        link_vld_d = 1'b0;
        state_d    = S_EXEC;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_FETCH;
      pc_q        <= PC_INIT;
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
      rdata_q     <= '0;
      link_word_q <= '0;
      link_vld_q  <= 1'b0;
      op_wr_q     <= 1'b0;
      op_atomic_q <= 1'b0;
      op_addr_q   <= '0;
      op_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      rdata_q     <= rdata_d;
      link_word_q <= link_word_d;
      link_vld_q  <= link_vld_d;
      op_wr_q     <= op_wr_d;
      op_atomic_q <= op_atomic_d;
      op_addr_q   <= op_addr_d;
      op_wdata_q  <= op_wdata_d;
    end
  end

  // cache requests decode straight from the state so they drop the cycle after RST
  assign imemREN   = (state_q == S_FETCH);
  assign imemaddr  = pc_q;
  assign dmemREN   = (state_q == S_DMEM) && !op_wr_q;
  assign dmemWEN   = (state_q == S_DMEM) && op_wr_q;
  assign datomic   = (state_q == S_DMEM) && op_atomic_q;
  assign dmemaddr  = (state_q == S_DMEM) ? op_addr_q  : '0;
  assign dmemstore = (state_q == S_DMEM) ? op_wdata_q : '0;
  assign halt      = (state_q == S_HALT);
  assign instr     = instr_q;
  assign instr_vld = instr_vld_q;
  assign pc        = pc_q;
  assign mem_done  = ((state_q == S_DMEM) && dhit) || (state_q == S_SCFAIL);
  // rdata_d equals rdata_q except on the completing cycle, where it carries the result
  assign mem_rdata = rdata_d;

endmodule

// File: tb/tb_datapath_mem_seq.sv
// Bench for datapath_mem_seq: directed fetch/load/LL/SC/halt/reset scenarios checked
// every cycle against a transaction-level model, plus literal per-scenario expectations.
module tb_datapath_mem_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, pc_we, mem_req, mem_wr, mem_atomic, halt_req, snoop_inv;
  logic [31:0] imemload, dmemload, pc_next, mem_addr, mem_wdata, snoop_addr;
  logic        imemREN, dmemREN, dmemWEN, datomic, halt, instr_vld, mem_done;
  logic [31:0] imemaddr, dmemstore, dmemaddr, instr, pc, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  datapath_mem_seq #(.ADDR_W(32), .DATA_W(32), .PC_INIT(32'h0)) dut (
    .CLK(CLK), .RST(RST),
    .ihit(ihit), .imemload(imemload), .imemREN(imemREN), .imemaddr(imemaddr),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .datomic(datomic), .dmemstore(dmemstore), .dmemaddr(dmemaddr), .halt(halt),
    .instr(instr), .instr_vld(instr_vld), .pc(pc),
    .pc_we(pc_we), .pc_next(pc_next),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_atomic(mem_atomic),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .halt_req(halt_req), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  localparam int M_FETCH = 0, M_EXEC = 1, M_DMEM = 2, M_SCFAIL = 3, M_HALT = 4;
  int          m_mode;
  bit          m_live = 0;
  logic [31:0] m_pc, m_instr, m_last, m_addr, m_wdata;
  logic        m_ivld, m_link_vld, m_wr, m_at;
  logic [29:0] m_link_word;

  function automatic logic [31:0] exp_rdata();
    if (m_mode == M_SCFAIL) return 32'h0;
    if (m_mode == M_DMEM && dhit) begin
      if (!m_wr) return dmemload;
      if (m_at)  return 32'h1;
    end
    return m_last;
  endfunction

  // Inputs only change just after a rising edge, so values seen at the falling
  // edge are exactly what the next rising edge samples.
  initial forever begin
    @(negedge CLK);
    if (m_live) begin
      chk("imemREN",   imemREN,   m_mode == M_FETCH);
      chk("imemaddr",  imemaddr,  m_pc);
      chk("dmemREN",   dmemREN,   m_mode == M_DMEM && !m_wr);
      chk("dmemWEN",   dmemWEN,   m_mode == M_DMEM && m_wr);
      chk("datomic",   datomic,   m_mode == M_DMEM && m_at);
      chk("dmemaddr",  dmemaddr,  (m_mode == M_DMEM) ? m_addr : 32'h0);
      chk("dmemstore", dmemstore, (m_mode == M_DMEM) ? m_wdata : 32'h0);
      chk("halt",      halt,      m_mode == M_HALT);
      chk("instr",     instr,     m_instr);
      chk("instr_vld", instr_vld, m_ivld);
      chk("pc",        pc,        m_pc);
      chk("mem_done",  mem_done,  (m_mode == M_DMEM && dhit) || m_mode == M_SCFAIL);
      chk("mem_rdata", mem_rdata, exp_rdata());
    end
    // advance the model to what the coming rising edge produces
    if (RST) begin
      m_live = 1; m_mode = M_FETCH; m_pc = 32'h0; m_instr = 32'h0; m_last = 32'h0;
      m_ivld = 0; m_link_vld = 0; m_link_word = '0;
      m_wr = 0; m_at = 0; m_addr = 32'h0; m_wdata = 32'h0;
    end else if (m_live) begin
      m_last = exp_rdata();
      if (snoop_inv && m_link_vld && snoop_addr[31:2] == m_link_word) m_link_vld = 0;
      m_ivld = 0;
      case (m_mode)
        M_FETCH: if (ihit) begin m_instr = imemload; m_ivld = 1; m_mode = M_EXEC; end
        M_EXEC: begin
          if (halt_req) m_mode = M_HALT;
          else if (mem_req) begin
            m_wr = mem_wr; m_at = mem_atomic; m_addr = mem_addr; m_wdata = mem_wdata;
            if (mem_wr && mem_atomic && !(m_link_vld && mem_addr[31:2] == m_link_word))
              m_mode = M_SCFAIL;
            else
              m_mode = M_DMEM;
          end else if (pc_we) begin
            m_pc = pc_next; m_mode = M_FETCH;
          end
        end
        M_DMEM: if (dhit) begin
          m_mode = M_EXEC;
          if (!m_wr && m_at) begin m_link_vld = 1; m_link_word = m_addr[31:2]; end
          else if (m_wr && m_at) m_link_vld = 0;
          else if (m_wr && m_link_vld && m_addr[31:2] == m_link_word) m_link_vld = 0;
        end
        M_SCFAIL: begin m_link_vld = 0; m_mode = M_EXEC; end
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  logic        op_done, op_wen, op_at, op_stable;
  logic [31:0] op_rdata, op_store;
  int          op_cycles;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 0; imemload = 0; dhit = 0; dmemload = 0; pc_we = 0; pc_next = 0;
    mem_req = 0; mem_wr = 0; mem_atomic = 0; mem_addr = 0; mem_wdata = 0;
    halt_req = 0; snoop_inv = 0; snoop_addr = 0;
  endtask

  // Issue one data op from EXEC; dhit after 'hold' cycles; snoop_at selects a
  // same-address snoop on the request cycle (0) or on op cycle snoop_at-1.
  task automatic mem_op(input logic wr, input logic at, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, input logic [31:0] load,
                        input int snoop_at);
    mem_req = 1; mem_wr = wr; mem_atomic = at; mem_addr = addr; mem_wdata = wd;
    snoop_inv = (snoop_at == 0); snoop_addr = addr;
    step();
    mem_req = 0; mem_wr = 0; mem_atomic = 0; mem_addr = 0; mem_wdata = 0; snoop_inv = 0;
    op_done = 0; op_wen = 0; op_at = 0; op_stable = 1; op_rdata = 0; op_store = 0;
    op_cycles = 0;
    for (int i = 0; i <= hold + 2 && !op_done; i++) begin
      dhit      = (i >= hold);
      dmemload  = (i >= hold) ? load : 32'hBAD0_0000;
      snoop_inv = (snoop_at == i + 1);
      #2;
      if (dmemREN || dmemWEN) begin
        op_cycles++;
        if (dmemaddr !== addr || dmemREN !== !wr || dmemWEN !== wr) op_stable = 0;
      end
      if (dmemWEN) op_store = dmemstore;
      op_wen = op_wen | dmemWEN;
      op_at  = op_at | datomic;
      if (mem_done === 1'b1) begin op_done = 1; op_rdata = mem_rdata; end
      step();
    end
    dhit = 0; dmemload = 0; snoop_inv = 0;
    chk("op_complete", op_done, 1'b1);
  endtask

  task automatic fetch(input logic [31:0] word);
    ihit = 1; imemload = word;
    #2;
    step();
    ihit = 0; imemload = 0;
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    step(); step();
    RST = 0;
    #2;
    chk("rst_imemREN", imemREN, 1'b1);
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_dmemREN", dmemREN, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    step();
    // 1: fetch after two waiting cycles, dhit must be ignored while fetching
    dhit = 1; dmemload = 32'h5555_AAAA;
    #2; chk("t1_imemaddr", imemaddr, 32'h0); chk("t1_no_done", mem_done, 1'b0);
    step();
    dhit = 0; dmemload = 0; ihit = 1; imemload = 32'h8C22_0004;
    #2; chk("t1_imemREN", imemREN, 1'b1);
    step();
    ihit = 0; imemload = 0;
    #2; chk("t1_instr", instr, 32'h8C22_0004); chk("t1_vld_pulse", instr_vld, 1'b1);
    step();
    #2; chk("t1_vld_low", instr_vld, 1'b0); chk("t1_instr_hold", instr, 32'h8C22_0004);
    step();
    // 2: load with dhit held off three cycles
    mem_op(1'b0, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, -1);
    chk("t2_cycles", op_cycles, 32'd4);
    chk("t2_stable", op_stable, 1'b1);
    chk("t2_rdata", op_rdata, 32'hDEAD_BEEF);
    #2; chk("t2_rdata_hold", mem_rdata, 32'hDEAD_BEEF); chk("t2_done_low", mem_done, 1'b0);
    step();
    // 3: LL then SC succeeds, repeated SC fails
    mem_op(1'b0, 1'b1, 32'h200, 32'h0, 1, 32'h1234_5678, -1);
    chk("t3_ll_rdata", op_rdata, 32'h1234_5678);
    mem_op(1'b1, 1'b1, 32'h200, 32'h5, 0, 32'h0, -1);
    chk("t3_sc_wen", op_wen, 1'b1); chk("t3_sc_atomic", op_at, 1'b1);
    chk("t3_sc_store", op_store, 32'h5); chk("t3_sc_rdata", op_rdata, 32'h1);
    mem_op(1'b1, 1'b1, 32'h200, 32'h6, 0, 32'h0, -1);
    chk("t3_sc2_wen", op_wen, 1'b0); chk("t3_sc2_rdata", op_rdata, 32'h0);
    // 4: snoop inside the linked word kills the link
    mem_op(1'b0, 1'b1, 32'h200, 32'h0, 0, 32'h0000_0011, -1);
    snoop_inv = 1; snoop_addr = 32'h202;
    #2; step();
    snoop_inv = 0; snoop_addr = 0;
    mem_op(1'b1, 1'b1, 32'h200, 32'h5, 0, 32'h0, -1);
    chk("t4_wen", op_wen, 1'b0); chk("t4_rdata", op_rdata, 32'h0);
    // snoop to a neighbouring word leaves the link alone
    mem_op(1'b0, 1'b1, 32'h200, 32'h0, 0, 32'h22, -1);
    snoop_inv = 1; snoop_addr = 32'h204;
    #2; step();
    snoop_inv = 0; snoop_addr = 0;
    mem_op(1'b1, 1'b1, 32'h200, 32'h9, 0, 32'h0, -1);
    chk("nb_sc_rdata", op_rdata, 32'h1);
    // plain store to the linked word kills the link
    mem_op(1'b0, 1'b1, 32'h200, 32'h0, 0, 32'h33, -1);
    mem_op(1'b1, 1'b0, 32'h200, 32'h7, 0, 32'h0, -1);
    mem_op(1'b1, 1'b1, 32'h200, 32'h8, 0, 32'h0, -1);
    chk("st_sc_rdata", op_rdata, 32'h0);
    // snoop in the same cycle as the SC request wins
    mem_op(1'b0, 1'b1, 32'h200, 32'h0, 0, 32'h44, -1);
    mem_op(1'b1, 1'b1, 32'h200, 32'hA, 0, 32'h0, 0);
    chk("sr_sc_wen", op_wen, 1'b0); chk("sr_sc_rdata", op_rdata, 32'h0);
    // snoop while the SC sits in DMEM does not undo it
    mem_op(1'b0, 1'b1, 32'h200, 32'h0, 0, 32'h55, -1);
    mem_op(1'b1, 1'b1, 32'h200, 32'hB, 2, 32'h0, 1);
    chk("sd_sc_wen", op_wen, 1'b1); chk("sd_sc_rdata", op_rdata, 32'h1);
    // LL completing alongside a matching snoop keeps the link
    mem_op(1'b0, 1'b1, 32'h300, 32'h0, 0, 32'h66, -1);
    mem_op(1'b0, 1'b1, 32'h300, 32'h0, 0, 32'h77, 1);
    mem_op(1'b1, 1'b1, 32'h300, 32'hC, 0, 32'h0, -1);
    chk("ls_sc_rdata", op_rdata, 32'h1);
    // pc_we starts a new fetch at pc_next
    pc_we = 1; pc_next = 32'h40;
    #2; step();
    pc_we = 0; pc_next = 0;
    #2; chk("pc_fetch_addr", imemaddr, 32'h40); chk("pc_fetch_ren", imemREN, 1'b1);
    fetch(32'h2000_0001);
    #2; chk("pc_instr", instr, 32'h2000_0001);
    step();
    // 5: halt_req beats pc_we; HALT ignores everything until reset
    pc_we = 1; pc_next = 32'h80; halt_req = 1;
    #2; step();
    halt_req = 0; ihit = 1; imemload = 32'hFFFF_FFFF; mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t5_halt", halt, 1'b1); chk("t5_pc", pc, 32'h40); chk("t5_no_iren", imemREN, 1'b0);
      step();
    end
    idle_inputs();
    RST = 1;
    #2; step();
    RST = 0;
    #2; chk("t5_halt_clr", halt, 1'b0); chk("t5_pc_init", pc, 32'h0);
    step();
    // 6: reset in the middle of a store drops it and clears the link
    fetch(32'h0000_0C0C);
    mem_op(1'b0, 1'b1, 32'h200, 32'h0, 0, 32'h88, -1);
    mem_req = 1; mem_wr = 1; mem_addr = 32'h300; mem_wdata = 32'hAA;
    #2; step();
    idle_inputs();
    #2; chk("t6_wen_before", dmemWEN, 1'b1);
    step();
    RST = 1;
    #2; step();
    RST = 0;
    #2;
    chk("t6_wen", dmemWEN, 1'b0); chk("t6_iren", imemREN, 1'b1); chk("t6_pc", pc, 32'h0);
    step();
    fetch(32'h0000_0D0D);
    mem_op(1'b1, 1'b1, 32'h200, 32'hD, 0, 32'h0, -1);
    chk("t6_sc_wen", op_wen, 1'b0); chk("t6_sc_rdata", op_rdata, 32'h0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
